pixel_frame_buffer: RTL
=======================

PIXEL_FRAME_BUFFER -- requirements
Module: pixel_frame_buffer

Parameters
REQ-001 Parameter COLS, default 32, panel width in pixels; power of two.
REQ-002 Parameter ROWS, default 32, panel height in pixels; power of two; upper half = rows 0..ROWS/2-1, lower half = rows ROWS/2..ROWS-1.

Interface
REQ-003 CLK_I  input  1  system clock; all logic rising-edge.
REQ-004 RSTN_I  input  1  asynchronous, active-low reset.
REQ-005 WR_VALID_I  input  1  writer presents a pixel.
REQ-006 WR_READY_O  output  1  buffer accepts a pixel; write occurs when WR_VALID_I and WR_READY_O are both 1.
REQ-007 WR_X_I  input  log2(COLS)  pixel column.
REQ-008 WR_Y_I  input  log2(ROWS)  pixel row.
REQ-009 WR_RGB_I  input  3  pixel colour {R,G,B}.
REQ-010 WR_COMMIT_I  input  1  single-cycle pulse: back bank complete, request swap.
REQ-011 RD_EN_I  input  1  scan driver read strobe.
REQ-012 RD_ROW_I  input  log2(ROWS)-1  row-pair address (matches RA..RD).
REQ-013 RD_COL_I  input  log2(COLS)  column being shifted.
REQ-014 RD_TOP_O  output  3  {R0,G0,B0} for pixel (RD_COL_I, RD_ROW_I).
REQ-015 RD_BOT_O  output  3  {R1,G1,B1} for pixel (RD_COL_I, RD_ROW_I+ROWS/2).
REQ-016 RD_VALID_O  output  1  RD_TOP_O/RD_BOT_O valid.
REQ-017 FRAME_END_I  input  1  single-cycle pulse from scan driver after last row of a frame is latched.
REQ-018 FRONT_O  output  1  index of bank currently displayed.
REQ-019 FRAME_CNT_O  output  8  count of completed swaps, wraps 255->0.

Function
REQ-020 Two banks of COLS*ROWS 3-bit pixels SHALL exist; writer always targets back bank (~FRONT_O), reader always targets front bank (FRONT_O); banks never accessed by both ports in the same cycle.
REQ-021 Accepted write SHALL store WR_RGB_I at back[WR_Y_I*COLS+WR_X_I] on that clock edge; rewriting an address overwrites.
REQ-022 Read latency SHALL be exactly 1 cycle: RD_EN_I at edge N -> RD_TOP_O/RD_BOT_O/RD_VALID_O=1 after edge N+1; RD_VALID_O=0 in cycles following RD_EN_I=0; data outputs hold last value when RD_EN_I=0.
REQ-023 Back-to-back reads SHALL sustain one pixel pair per cycle.
REQ-024 FSM states: FILL (WR_READY_O=1) and PENDING (WR_READY_O=0).
REQ-025 FILL -> PENDING on WR_COMMIT_I=1 when FRAME_END_I=0; a write accepted in that same cycle SHALL complete into the old back bank.
REQ-026 PENDING -> FILL on FRAME_END_I=1: FRONT_O toggles, FRAME_CNT_O increments, same edge.
REQ-027 WR_COMMIT_I and FRAME_END_I both 1 in FILL SHALL swap immediately and remain in FILL (no PENDING cycle).
REQ-028 FRAME_END_I in FILL without commit SHALL have no effect; WR_COMMIT_I in PENDING SHALL be ignored.
REQ-029 WR_VALID_I in PENDING SHALL not write; writer holds data until WR_READY_O=1.
REQ-030 A read issued in the same cycle as a swap SHALL return data from the pre-swap front bank; reads from the next cycle use the new front bank.
REQ-031 WR_READY_O SHALL be a registered state decode, not combinationally dependent on WR_VALID_I.

Reset
REQ-032 RSTN_I=0 SHALL force asynchronously: state FILL, WR_READY_O=1, FRONT_O=0, FRAME_CNT_O=0, RD_VALID_O=0, RD_TOP_O=0, RD_BOT_O=0.
REQ-033 Bank contents SHALL not be reset; reset mid-PENDING discards the commit request.
REQ-034 Outputs SHALL leave reset values only on the first rising edge after RSTN_I deasserts.

Verification
REQ-035 Reset, write (x=3,y=5,RGB=3'b101) and (x=3,y=21,RGB=3'b010), commit, FRAME_END -> FRONT_O=1, FRAME_CNT_O=1; read row 5 col 3 -> next cycle TOP=101, BOT=010, RD_VALID_O=1.
REQ-036 Commit, then FRAME_END 10 cycles later -> WR_READY_O=0 for exactly those 10 cycles; writes held by WR_VALID_I during PENDING land in the new back bank afterwards.
REQ-037 WR_COMMIT_I and FRAME_END_I asserted same cycle -> swap that edge, WR_READY_O never drops.
REQ-038 Continuous reads of cols 0..31 on row 0 with a swap mid-stream -> pre-swap pixels from old bank, post-swap from new, no missing or duplicated RD_VALID_O pulse.
REQ-039 256 swaps -> FRAME_CNT_O returns to 0, FRONT_O back to 0.
REQ-040 RSTN_I pulsed low while PENDING -> FILL, WR_READY_O=1, FRONT_O=0, FRAME_CNT_O=0 immediately; subsequent FRAME_END_I causes no swap.

Source files
------------

// File: rtl/pixel_frame_buffer.sv
// Double-buffered RGB frame store for a row-pair scanned LED panel.
// Writer fills the back bank; a commit swaps banks at the next frame end.
module pixel_frame_buffer #(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS),
  localparam int AW = 1 + YW + XW
) (
  input  logic          CLK_I,
  input  logic          RSTN_I,
  input  logic          WR_VALID_I,
  output logic          WR_READY_O,
  input  logic [XW-1:0] WR_X_I,
  input  logic [YW-1:0] WR_Y_I,
  input  logic [2:0]    WR_RGB_I,
  input  logic          WR_COMMIT_I,
  input  logic          RD_EN_I,
  input  logic [YW-2:0] RD_ROW_I,
  input  logic [XW-1:0] RD_COL_I,
  output logic [2:0]    RD_TOP_O,
  output logic [2:0]    RD_BOT_O,
  output logic          RD_VALID_O,
  input  logic          FRAME_END_I,
  output logic          FRONT_O,
  output logic [7:0]    FRAME_CNT_O
);

  typedef enum logic {
    S_FILL,
    S_PENDING
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_swap;
  logic   r_front;
  logic [7:0] r_cnt;

  logic [2:0] r_mem [2*COLS*ROWS];
  logic [2:0] r_top;
  logic [2:0] r_bot;
  logic       r_rd_vld;

  logic          w_wr;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_top_addr;
  logic [AW-1:0] w_bot_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    unique case (r_state)
      S_FILL: begin
        if (WR_COMMIT_I && FRAME_END_I) begin
          w_swap = 1'b1;
        end else if (WR_COMMIT_I) begin
          w_state_nxt = S_PENDING;
        end
      end
      S_PENDING: begin
        if (FRAME_END_I) begin
          w_swap      = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_state <= S_FILL;
      r_front <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_swap) begin
        r_front <= ~r_front;
        r_cnt   <= r_cnt + 8'd1;
      end
    end
  end

  assign WR_READY_O = (r_state == S_FILL);
  assign w_wr       = WR_VALID_I & WR_READY_O;
  assign w_wr_addr  = {~r_front, WR_Y_I, WR_X_I};
  assign w_top_addr = {r_front, 1'b0, RD_ROW_I, RD_COL_I};
  assign w_bot_addr = {r_front, 1'b1, RD_ROW_I, RD_COL_I};

  // Pixel storage is deliberately left out of reset.
  always_ff @(posedge CLK_I) begin
    if (w_wr) begin
      r_mem[w_wr_addr] <= WR_RGB_I;
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_top    <= 3'd0;
      r_bot    <= 3'd0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= RD_EN_I;
      if (RD_EN_I) begin
        r_top <= r_mem[w_top_addr];
        r_bot <= r_mem[w_bot_addr];
      end
    end
  end

  assign RD_TOP_O    = r_top;
  assign RD_BOT_O    = r_bot;
  assign RD_VALID_O  = r_rd_vld;
  assign FRONT_O     = r_front;
  assign FRAME_CNT_O = r_cnt;

endmodule
